// File: rtl/handshake_receiver_pkg.sv
// Shared types and default parameters for the destination-side
// req/ack handshake receiver.
package hs_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } hs_rx_state_t;

  localparam int HS_RX_BIT_WIDTH      = 4;
  localparam int HS_RX_CNT_WIDTH      = 8;
  localparam int HS_RX_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/handshake_receiver_if.sv
// Bus bundle between the crossing/stream environment and handshake_receiver.
// slave  : the receiver itself.
// master : the environment (synchronized req, source data, stream consumer).
// timeout_errB exists only when HS_RX_TIMEOUT_EN is defined.
interface hs_rx_if
  import hs_rx_pkg::*;
#(
  parameter int BIT_WIDTH = HS_RX_BIT_WIDTH,
  parameter int CNT_WIDTH = HS_RX_CNT_WIDTH
) ();

  logic                 reqB_sync;
  logic [BIT_WIDTH-1:0] dataA;
  logic                 ackB;
  logic [BIT_WIDTH-1:0] doutB;
  logic                 doutB_valid;
  logic                 doutB_ready;
  logic [CNT_WIDTH-1:0] xfer_countB;
`ifdef HS_RX_TIMEOUT_EN
  logic                 timeout_errB;
`endif

  modport slave (
    input  reqB_sync, dataA, doutB_ready,
    output ackB, doutB, doutB_valid, xfer_countB
`ifdef HS_RX_TIMEOUT_EN
    , output timeout_errB
`endif
  );

  modport master (
    output reqB_sync, dataA, doutB_ready,
    input  ackB, doutB, doutB_valid, xfer_countB
`ifdef HS_RX_TIMEOUT_EN
    , input timeout_errB
`endif
  );

endinterface

// File: rtl/handshake_receiver_timeout_counter.sv
// ACK-dwell counter: held at zero while clear is high, counts while enable
// is high, and flags the cycle in which the count sits at TIMEOUT_CYCLES-1.
module hs_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rstN,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] cnt;

  // dwell count, zeroed outside the watched state
  always_ff @(posedge clk) begin
    if (!rstN || clear) cnt <= '0;
    else if (enable)    cnt <= cnt + W'(1);
  end

  assign tc = enable && (cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/handshake_receiver.sv
// Destination-domain consumer of a 4-phase req/ack crossing.
// Captures the (source-held) data bus when the synchronized req rises,
// offers it on a valid/ready stream, then acks the source until req drops.
// Optional feature macro: HS_RX_TIMEOUT_EN -- bounds the ACK dwell to
// TIMEOUT_CYCLES and pulses timeout_errB when the source never drops req.
module handshake_receiver
  import hs_rx_pkg::*;
#(
  parameter int BIT_WIDTH = HS_RX_BIT_WIDTH,
  parameter int CNT_WIDTH = HS_RX_CNT_WIDTH
`ifdef HS_RX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = HS_RX_TIMEOUT_CYCLES
`endif
) (
  input logic    clkB,
  input logic    rstN,
  hs_rx_if.slave bus
);

  hs_rx_state_t         state, stateNext;
  logic                 armed, armedNext;
  logic                 ackQ, ackNext;
  logic [BIT_WIDTH-1:0] doutQ, doutNext;
  logic                 validQ, validNext;
  logic [CNT_WIDTH-1:0] countQ, countNext;
  logic                 dwellTc;

`ifdef HS_RX_TIMEOUT_EN
  logic toErrQ, toErrNext;

  hs_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uDwell (
    .clk   (clkB),
    .rstN  (rstN),
    .clear (state != ACK),
    .enable(state == ACK),
    .tc    (dwellTc)
  );

  assign bus.timeout_errB = toErrQ;
`else
  assign dwellTc = 1'b0;
`endif

  // next-state and next-output decode; every register holds by default
  always_comb begin
    stateNext = state;
    // armed latches the first sampled req-low so a req already high at
    // reset release is never mistaken for a new request
    armedNext = armed | ~bus.reqB_sync;
    ackNext   = ackQ;
    doutNext  = doutQ;
    validNext = validQ;
    countNext = countQ;
`ifdef HS_RX_TIMEOUT_EN
    toErrNext = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (armed && bus.reqB_sync) begin
          doutNext  = bus.dataA;
          validNext = 1'b1;
          stateNext = VALID;
        end
      end
      VALID: begin
        // req is deliberately ignored here: the source may not drop it before ack
        if (bus.doutB_ready) begin
          validNext = 1'b0;
          ackNext   = 1'b1;
          countNext = countQ + CNT_WIDTH'(1);
          stateNext = ACK;
        end
      end
      ACK: begin
        if (!bus.reqB_sync) begin
          ackNext   = 1'b0;
          stateNext = IDLE;
        end else if (dwellTc) begin
          // stuck source: give up, and demand a fresh req-low before re-arming
          ackNext   = 1'b0;
          armedNext = 1'b0;
          stateNext = IDLE;
`ifdef HS_RX_TIMEOUT_EN
          toErrNext = 1'b1;
`endif
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // state and registered outputs, synchronous active-low reset
  always_ff @(posedge clkB) begin
    if (!rstN) begin
      state  <= IDLE;
      armed  <= 1'b0;
      ackQ   <= 1'b0;
      doutQ  <= '0;
      validQ <= 1'b0;
      countQ <= '0;
`ifdef HS_RX_TIMEOUT_EN
      toErrQ <= 1'b0;
`endif
    end else begin
      state  <= stateNext;
      armed  <= armedNext;
      ackQ   <= ackNext;
      doutQ  <= doutNext;
      validQ <= validNext;
      countQ <= countNext;
`ifdef HS_RX_TIMEOUT_EN
      toErrQ <= toErrNext;
`endif
    end
  end

  assign bus.ackB        = ackQ;
  assign bus.doutB       = doutQ;
  assign bus.doutB_valid = validQ;
  assign bus.xfer_countB = countQ;

endmodule

// File: tb/tb_handshake_receiver.sv
// Self-checking bench for handshake_receiver: expected captures go into a
// queue when req is raised and are popped when the stream beat is observed.
module tb_handshake_receiver;
  import hs_rx_pkg::*;

  localparam int BW = 4;
  localparam int CW = 8;

  logic clkB = 1'b0;
  logic rstN = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [BW-1:0] expQ[$];
  logic [CW-1:0] expCount = '0;
  logic [BW-1:0] expD;
  logic [BW-1:0] lastD;

  hs_rx_if #(.BIT_WIDTH(BW), .CNT_WIDTH(CW)) bus ();

`ifdef HS_RX_TIMEOUT_EN
  handshake_receiver #(.BIT_WIDTH(BW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(8)) dut (
    .clkB(clkB), .rstN(rstN), .bus(bus.slave));
`else
  handshake_receiver #(.BIT_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .clkB(clkB), .rstN(rstN), .bus(bus.slave));
`endif

  always #5 clkB = ~clkB;

  // advance one edge and sample #1 after it
  task automatic step();
    @(posedge clkB);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; bus.reqB_sync = 1'b1; bus.doutB_ready = 1'b0; bus.dataA = '0;
    step(); step();
    checks++; if (bus.ackB !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.ackB); end
    checks++; if (bus.doutB !== 4'h0) begin errors++; $display("FAIL reset_dout: got %h want 0", bus.doutB); end
    checks++; if (bus.doutB_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.doutB_valid); end
    checks++; if (bus.xfer_countB !== 8'h00) begin errors++; $display("FAIL reset_count: got %h want 0", bus.xfer_countB); end
`ifdef HS_RX_TIMEOUT_EN
    checks++; if (bus.timeout_errB !== 1'b0) begin errors++; $display("FAIL reset_toerr: got %b want 0", bus.timeout_errB); end
`endif
    // req already high at reset release must not be captured
    rstN = 1'b1; bus.dataA = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.doutB_valid !== 1'b0) begin errors++; $display("FAIL unarmed_valid[%0d]: got %b want 0", i, bus.doutB_valid); end
    end
    bus.reqB_sync = 1'b0; step();
    bus.dataA = 4'b1010; bus.reqB_sync = 1'b1; expQ.push_back(4'b1010);
    step();
    checks++; if (bus.doutB_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", bus.doutB_valid); end
    checks++; if (bus.doutB !== expQ[0]) begin errors++; $display("FAIL first_dout: got %h want %h", bus.doutB, expQ[0]); end
  endtask

  // enters in VALID holding 4'b1010 with ready low
  task automatic test_backpressure();
    for (int i = 0; i < 7; i++) begin
      bus.dataA = 4'(i);
      step();
      checks++; if (bus.doutB_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.doutB_valid); end
      checks++; if (bus.doutB !== expQ[0]) begin errors++; $display("FAIL bp_dout[%0d]: got %h want %h", i, bus.doutB, expQ[0]); end
      checks++; if (bus.ackB !== 1'b0) begin errors++; $display("FAIL bp_ack[%0d]: got %b want 0", i, bus.ackB); end
    end
    bus.doutB_ready = 1'b1;
    expD = expQ.pop_front();
    checks++; if (bus.doutB !== expD) begin errors++; $display("FAIL bp_beat_data: got %h want %h", bus.doutB, expD); end
    lastD = expD;
    expCount++;
    step();
    checks++; if (bus.ackB !== 1'b1) begin errors++; $display("FAIL bp_ack_rise: got %b want 1", bus.ackB); end
    checks++; if (bus.doutB_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b want 0", bus.doutB_valid); end
    checks++; if (bus.xfer_countB !== expCount) begin errors++; $display("FAIL bp_count: got %h want %h", bus.xfer_countB, expCount); end
    // data wiggling during ACK must not disturb doutB
    for (int i = 0; i < 3; i++) begin
      bus.dataA = 4'(4'hC + i);
      step();
      checks++; if (bus.doutB !== lastD) begin errors++; $display("FAIL ack_dout_hold[%0d]: got %h want %h", i, bus.doutB, lastD); end
      checks++; if (bus.ackB !== 1'b1) begin errors++; $display("FAIL ack_hold[%0d]: got %b want 1", i, bus.ackB); end
    end
    bus.reqB_sync = 1'b0; step();
    checks++; if (bus.ackB !== 1'b0) begin errors++; $display("FAIL bp_ack_fall: got %b want 0", bus.ackB); end
  endtask

  task automatic test_handshake();
    logic [BW-1:0] pat [3];
    pat[0] = 4'b1010; pat[1] = 4'b1100; pat[2] = 4'b1111;
    bus.doutB_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.dataA = pat[k]; bus.reqB_sync = 1'b1; expQ.push_back(pat[k]);
      step();
      checks++; if (bus.doutB_valid !== 1'b1) begin errors++; $display("FAIL hs_valid[%0d]: got %b want 1", k, bus.doutB_valid); end
      expD = expQ.pop_front();
      checks++; if (bus.doutB !== expD) begin errors++; $display("FAIL hs_data[%0d]: got %h want %h", k, bus.doutB, expD); end
      checks++; if (bus.ackB !== 1'b0) begin errors++; $display("FAIL hs_ack_early[%0d]: got %b want 0", k, bus.ackB); end
      expCount++;
      step();
      checks++; if (bus.ackB !== 1'b1) begin errors++; $display("FAIL hs_ack_rise[%0d]: got %b want 1", k, bus.ackB); end
      checks++; if (bus.xfer_countB !== expCount) begin errors++; $display("FAIL hs_count[%0d]: got %h want %h", k, bus.xfer_countB, expCount); end
      step();
      checks++; if (bus.ackB !== 1'b1) begin errors++; $display("FAIL hs_ack_hold[%0d]: got %b want 1", k, bus.ackB); end
      bus.reqB_sync = 1'b0;
      step();
      checks++; if (bus.ackB !== 1'b0) begin errors++; $display("FAIL hs_ack_fall[%0d]: got %b want 0", k, bus.ackB); end
    end
  endtask

  task automatic test_reset_mid();
    bus.doutB_ready = 1'b0; bus.dataA = 4'b0110; bus.reqB_sync = 1'b1; expQ.push_back(4'b0110);
    step();
    checks++; if (bus.doutB_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_pre: got %b want 1", bus.doutB_valid); end
    rstN = 1'b0; step(); rstN = 1'b1;
    expQ.delete(); expCount = '0;
    checks++; if (bus.doutB_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", bus.doutB_valid); end
    checks++; if (bus.doutB !== 4'h0) begin errors++; $display("FAIL mid_dout: got %h want 0", bus.doutB); end
    checks++; if (bus.ackB !== 1'b0) begin errors++; $display("FAIL mid_ack: got %b want 0", bus.ackB); end
    checks++; if (bus.xfer_countB !== expCount) begin errors++; $display("FAIL mid_count: got %h want %h", bus.xfer_countB, expCount); end
    bus.doutB_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.doutB_valid !== 1'b0) begin errors++; $display("FAIL mid_rearm[%0d]: got %b want 0", i, bus.doutB_valid); end
    end
    bus.reqB_sync = 1'b0; step();
    bus.dataA = 4'b1001; bus.reqB_sync = 1'b1; expQ.push_back(4'b1001);
    step();
    expD = expQ.pop_front();
    checks++; if (bus.doutB_valid !== 1'b1 || bus.doutB !== expD) begin errors++; $display("FAIL mid_recapture: got v=%b d=%h want v=1 d=%h", bus.doutB_valid, bus.doutB, expD); end
    expCount++;
    step(); bus.reqB_sync = 1'b0; step();
  endtask

  task automatic test_wrap();
    bus.doutB_ready = 1'b1;
    for (int i = 0; i < 300 && expCount != 8'hFF; i++) begin
      bus.dataA = 4'($urandom_range(0, 15)); bus.reqB_sync = 1'b1; expQ.push_back(bus.dataA);
      step();
      expD = expQ.pop_front();
      checks++; if (bus.doutB !== expD) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", i, bus.doutB, expD); end
      expCount++;
      step(); bus.reqB_sync = 1'b0; step();
    end
    checks++; if (bus.xfer_countB !== 8'hFF) begin errors++; $display("FAIL wrap_max: got %h want ff", bus.xfer_countB); end
    bus.dataA = 4'h3; bus.reqB_sync = 1'b1;
    step(); step();
    expCount++;
    checks++; if (bus.xfer_countB !== expCount) begin errors++; $display("FAIL wrap_zero: got %h want %h", bus.xfer_countB, expCount); end
    bus.reqB_sync = 1'b0; step();
  endtask

`ifdef HS_RX_TIMEOUT_EN
  task automatic test_timeout();
    bus.doutB_ready = 1'b1; bus.dataA = 4'b0111; bus.reqB_sync = 1'b1; expQ.push_back(4'b0111);
    step();
    expD = expQ.pop_front();
    checks++; if (bus.doutB !== expD) begin errors++; $display("FAIL to_data: got %h want %h", bus.doutB, expD); end
    step();
    checks++; if (bus.ackB !== 1'b1) begin errors++; $display("FAIL to_ack_entry: got %b want 1", bus.ackB); end
    for (int j = 1; j < 8; j++) begin
      step();
      checks++; if (bus.timeout_errB !== 1'b0 || bus.ackB !== 1'b1) begin errors++; $display("FAIL to_dwell[%0d]: got err=%b ack=%b want err=0 ack=1", j, bus.timeout_errB, bus.ackB); end
    end
    step();
    checks++; if (bus.timeout_errB !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b want 1", bus.timeout_errB); end
    checks++; if (bus.ackB !== 1'b0) begin errors++; $display("FAIL to_ack_drop: got %b want 0", bus.ackB); end
    for (int j = 0; j < 3; j++) begin
      step();
      checks++; if (bus.timeout_errB !== 1'b0 || bus.doutB_valid !== 1'b0) begin errors++; $display("FAIL to_after[%0d]: got err=%b v=%b want 0 0", j, bus.timeout_errB, bus.doutB_valid); end
    end
    bus.reqB_sync = 1'b0; step();
    bus.dataA = 4'b1110; bus.reqB_sync = 1'b1; expQ.push_back(4'b1110);
    step();
    expD = expQ.pop_front();
    checks++; if (bus.doutB_valid !== 1'b1 || bus.doutB !== expD) begin errors++; $display("FAIL to_recapture: got v=%b d=%h want v=1 d=%h", bus.doutB_valid, bus.doutB, expD); end
    step(); bus.reqB_sync = 1'b0; step();
  endtask
`endif

  initial begin
    bus.reqB_sync = 1'b0; bus.dataA = '0; bus.doutB_ready = 1'b0;
    test_reset();
    test_backpressure();
    test_handshake();
    test_reset_mid();
    test_wrap();
`ifdef HS_RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/handshake_receiver.md
# handshake_receiver

Destination-domain consumer of a 4-phase req/ack crossing. The request bit arrives already synchronized by the multi-flop synchronizer; the data bus arrives unsynchronized and is held stable by the source for the whole time req is high. The block captures that bus, presents it on a valid/ready stream and drives ack back toward the source domain through a second synchronizer. Per-transfer cost: one capture, one stream beat, one full four-phase round trip.

## Interface
- BIT_WIDTH, 4: data bus width.
- CNT_WIDTH, 8: width of the transfer counter.
- TIMEOUT_CYCLES, 64: maximum ACK-state dwell, in clkB cycles; used only when HS_RX_TIMEOUT_EN is defined.
- clkB  input  1  destination clock. One clock; everything is on its rising edge.
- rstN  input  1  reset, synchronous, active-low.
- reqB_sync  input  1  request from the synchronizer output.
- dataA  input  BIT_WIDTH  source-domain bus. Sampled only in the cycle the capture condition is true.
- ackB  output  1  acknowledge to the source domain. Registered, glitch-free.
- doutB  output  BIT_WIDTH  captured data.
- doutB_valid  output  1  stream valid.
- doutB_ready  input  1  stream ready from the consumer.
- xfer_countB  output  CNT_WIDTH  count of completed stream beats. Wraps modulo 2^CNT_WIDTH.
- timeout_errB  output  1  one-cycle pulse on ACK timeout. Exists only when HS_RX_TIMEOUT_EN is defined.

## Operation
- States: IDLE, VALID, ACK.
- Armed flag:
  - Cleared by reset.
  - Set by the first cycle in which reqB_sync=0 is sampled.
  - IDLE ignores req until armed, so a req already high at reset release is never captured.
- IDLE:
  - Capture condition is armed and reqB_sync=1.
  - On capture: doutB<=dataA, doutB_valid<=1, go to VALID.
- VALID:
  - doutB and doutB_valid are held until doutB_valid&&doutB_ready is sampled.
  - On the transfer cycle: doutB_valid<=0, ackB<=1, xfer_countB<=xfer_countB+1, go to ACK.
  - reqB_sync is ignored in VALID. The protocol forbids the source from dropping req before ack.
- ACK:
  - ackB is held at 1 while reqB_sync=1.
  - When reqB_sync=0 is sampled: ackB<=0, go to IDLE.
- doutB keeps the last captured value outside VALID. It changes only on capture.
- Reset mid-operation, in any state: next edge forces IDLE, ackB=0, doutB_valid=0, doutB=0, xfer_countB=0, armed=0. Any in-flight beat is discarded.

## Timing
- Reset values: ackB=0, doutB=0, doutB_valid=0, xfer_countB=0, timeout_errB=0, state IDLE.
- Capture latency: reqB_sync high at edge N (IDLE, armed) gives doutB_valid=1 and doutB updated after edge N.
- Ready already high: the beat completes at edge N+1. ackB=1 after edge N+1.
- ack release: reqB_sync low at edge M in ACK gives ackB=0 after M. The block is in IDLE and may capture again at M+1 at the earliest.
- Maximum throughput: one beat per complete four-phase round trip. No buffering.
- Counter wrap: at 2^CNT_WIDTH-1, the next beat gives 0. No flag is raised.

## Configuration
- HS_RX_TIMEOUT_EN defined:
  - An ACK-dwell counter runs in ACK, cleared on entry.
  - When it reaches TIMEOUT_CYCLES-1 with reqB_sync still 1:
    - timeout_errB pulses for one cycle.
    - ackB<=0, armed<=0, go to IDLE.
  - The block then waits for req low before re-arming.
- HS_RX_TIMEOUT_EN undefined:
  - ACK waits indefinitely.
  - No timeout counter and no timeout_errB port.

## Structure
- Package hs_rx_pkg holds:
  - typedef enum logic [1:0] hs_rx_state_t {IDLE, VALID, ACK}.
  - Default parameter constants.
- Sub-module hs_timeout_counter: clear, enable, terminal-count pulse, width $clog2(TIMEOUT_CYCLES). Instantiated only under HS_RX_TIMEOUT_EN.

## Test plan
- Reset release with reqB_sync=1 held for 5 cycles -> no capture, doutB_valid stays 0. Req drop then rise with dataA=4'b1010 -> doutB=4'b1010 and doutB_valid=1 one cycle later.
- Full handshake, ready always 1, data 4'b1010, 4'b1100, 4'b1111 -> three beats with matching doutB and xfer_countB=3. Each ackB rise occurs one cycle after its beat; each ackB fall occurs one cycle after req low.
- Backpressure: ready=0 for 7 cycles after capture -> doutB and doutB_valid stable for all 7 cycles, ackB=0. Ready=1 -> beat completes and ackB=1 on the next edge.
- dataA changed during VALID and ACK -> doutB unchanged.
- rstN=0 for one cycle while in VALID -> next cycle all outputs 0 and state IDLE. The re-arm rule applies.
- Under HS_RX_TIMEOUT_EN, TIMEOUT_CYCLES=8, req held high in ACK -> timeout_errB pulses exactly once, 8 cycles after ACK entry, and ackB=0. No capture occurs until req falls and rises again.
- xfer_countB wrap: CNT_WIDTH=2, five beats -> xfer_countB=1.
